wb_commit_unit: RTL and testbench

- Write-back end of the MEM/WB pipeline register.
- Consumes the registered write-back bundle: GPR write, HI/LO write and LLbit write.
- Holds the architectural state: 32x32 GPR file, HI, LO and the LLbit.
- Serves the decode-stage GPR reads, the execute-stage HI/LO reads and the memory-stage LLbit read, each with same-cycle write-through bypass.
- Keeps a committed-GPR-write counter for debug.

---
 rtl/wb_commit_unit_if.sv | 37 +++
 rtl/wb_commit_unit.sv | 99 +++++++++
 tb/tb_wb_commit_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/wb_commit_unit_if.sv
// MEM/WB write-back bundle plus the GPR/HI/LO/LLbit read-side signals of the commit unit.
// Master drives the write-back bundle and read requests; slave is the commit unit.
interface wb_commit_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       wb_wd;
    logic             wb_wreg;
    logic [31:0]      wb_wdata;
    logic [31:0]      wb_hi;
    logic [31:0]      wb_lo;
    logic             wb_whilo;
    logic             wb_LLbit_we;
    logic             wb_LLbit_value;
    logic             flush;
    logic             re1;
    logic [4:0]       raddr1;
    logic [31:0]      rdata1;
    logic             re2;
    logic [4:0]       raddr2;
    logic [31:0]      rdata2;
    logic [31:0]      hi_o;
    logic [31:0]      lo_o;
    logic             LLbit_o;
    logic [CNT_W-1:0] commit_cnt;

    modport master (
        output wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
               wb_LLbit_we, wb_LLbit_value, flush, re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, hi_o, lo_o, LLbit_o, commit_cnt
    );

    modport slave (
        input  wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
               wb_LLbit_we, wb_LLbit_value, flush, re1, raddr1, re2, raddr2,
        output rdata1, rdata2, hi_o, lo_o, LLbit_o, commit_cnt
    );
endinterface

// File: rtl/wb_commit_unit.sv
// Write-back commit unit: GPR file, HI/LO, LLbit and a committed-write counter,
// with same-cycle write-through bypass on every read path.
module wb_commit_unit #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned CNT_W    = 32
) (
    input logic             clk,
    input logic             rst,
    wb_commit_unit_if.slave wb
);
    logic [31:0]      gpr_q [NUM_REGS];
    logic [31:0]      gpr_d [NUM_REGS];
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             llbit_q, llbit_d;
    logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;
    logic             gpr_we;

    // r0 is never written, so its storage stays at the reset value of zero.
    assign gpr_we = wb.wb_wreg && (wb.wb_wd != '0);

    always_comb begin
        gpr_d        = gpr_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        llbit_d      = llbit_q;
        commit_cnt_d = commit_cnt_q;
        if (gpr_we) begin
            gpr_d[wb.wb_wd] = wb.wb_wdata;
            commit_cnt_d    = commit_cnt_q + CNT_W'(1);
        end
        if (wb.wb_whilo) begin
            hi_d = wb.wb_hi;
            lo_d = wb.wb_lo;
        end
        if (wb.flush) begin
            llbit_d = 1'b0;
        end else if (wb.wb_LLbit_we) begin
            llbit_d = wb.wb_LLbit_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpr_q        <= '{default: '0};
            hi_q         <= '0;
            lo_q         <= '0;
            llbit_q      <= 1'b0;
            commit_cnt_q <= '0;
        end else begin
            gpr_q        <= gpr_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            llbit_q      <= llbit_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    always_comb begin
        wb.rdata1 = '0;
        if (!rst && wb.re1 && (wb.raddr1 != '0)) begin
            if (wb.wb_wreg && (wb.wb_wd == wb.raddr1)) begin
                wb.rdata1 = wb.wb_wdata;
            end else begin
                wb.rdata1 = gpr_q[wb.raddr1];
            end
        end
    end

    always_comb begin
        wb.rdata2 = '0;
        if (!rst && wb.re2 && (wb.raddr2 != '0)) begin
            if (wb.wb_wreg && (wb.wb_wd == wb.raddr2)) begin
                wb.rdata2 = wb.wb_wdata;
            end else begin
                wb.rdata2 = gpr_q[wb.raddr2];
            end
        end
    end

    always_comb begin
        wb.hi_o    = '0;
        wb.lo_o    = '0;
        wb.LLbit_o = 1'b0;
        if (!rst) begin
            wb.hi_o = wb.wb_whilo ? wb.wb_hi : hi_q;
            wb.lo_o = wb.wb_whilo ? wb.wb_lo : lo_q;
            if (wb.flush) begin
                wb.LLbit_o = 1'b0;
            end else if (wb.wb_LLbit_we) begin
                wb.LLbit_o = wb.wb_LLbit_value;
            end else begin
                wb.LLbit_o = llbit_q;
            end
        end
    end

    assign wb.commit_cnt = commit_cnt_q;
endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed, table-driven bench for wb_commit_unit (4-bit counter to reach the wrap quickly).
module tb_wb_commit_unit;
    localparam int unsigned CW = 4;

    logic clk;
    logic rst;

    wb_commit_unit_if #(.CNT_W(CW)) bus ();

    wb_commit_unit #(.NUM_REGS(32), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          wreg;
        logic [4:0]    wd;
        logic [31:0]   wdata;
        logic          whilo;
        logic [31:0]   hi;
        logic [31:0]   lo;
        logic          llwe;
        logic          llval;
        logic          flush;
        logic          re1;
        logic [4:0]    ra1;
        logic          re2;
        logic [4:0]    ra2;
        logic [31:0]   e_rd1;
        logic [31:0]   e_rd2;
        logic [31:0]   e_hi;
        logic [31:0]   e_lo;
        logic          e_ll;
        logic [CW-1:0] e_cnt;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst                = v.rst;
        bus.wb_wreg        = v.wreg;
        bus.wb_wd          = v.wd;
        bus.wb_wdata       = v.wdata;
        bus.wb_whilo       = v.whilo;
        bus.wb_hi          = v.hi;
        bus.wb_lo          = v.lo;
        bus.wb_LLbit_we    = v.llwe;
        bus.wb_LLbit_value = v.llval;
        bus.flush          = v.flush;
        bus.re1            = v.re1;
        bus.raddr1         = v.ra1;
        bus.re2            = v.re2;
        bus.raddr2         = v.ra2;
    endtask

    // Drive on the falling edge, check 1 time unit later; the rising edge commits the row.
    task automatic run(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check($sformatf("%s_rdata1", tag), bus.rdata1, v.e_rd1);
        check($sformatf("%s_rdata2", tag), bus.rdata2, v.e_rd2);
        check($sformatf("%s_hi_o", tag), bus.hi_o, v.e_hi);
        check($sformatf("%s_lo_o", tag), bus.lo_o, v.e_lo);
        check($sformatf("%s_LLbit_o", tag), {31'b0, bus.LLbit_o}, {31'b0, v.e_ll});
        check($sformatf("%s_commit_cnt", tag), {{(32-CW){1'b0}}, bus.commit_cnt},
              {{(32-CW){1'b0}}, v.e_cnt});
    endtask

    vec_t vecs [16];
    vec_t v;

    initial begin
        // Fields: rst,wreg,wd,wdata,whilo,hi,lo,llwe,llval,flush, re1,ra1,re2,ra2,
        //         exp rdata1,rdata2,hi,lo,LLbit,cnt
        vecs[0]  = '{1'b1,1'b1,5'd5,32'h000000AA,1'b1,32'h11,32'h22,1'b1,1'b1,1'b0, 1'b1,5'd5,1'b1,5'd31,
                     32'h0,32'h0,32'h0,32'h0,1'b0,4'd0};
        vecs[1]  = '{1'b0,1'b0,5'd0,32'h0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0, 1'b1,5'd5,1'b1,5'd31,
                     32'h0,32'h0,32'h0,32'h0,1'b0,4'd0};
        vecs[2]  = '{1'b0,1'b1,5'd3,32'hDEADBEEF,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0, 1'b1,5'd3,1'b1,5'd3,
                     32'hDEADBEEF,32'hDEADBEEF,32'h0,32'h0,1'b0,4'd0};
        vecs[3]  = '{1'b0,1'b0,5'd0,32'h0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0, 1'b1,5'd3,1'b1,5'd3,
                     32'hDEADBEEF,32'hDEADBEEF,32'h0,32'h0,1'b0,4'd1};
        vecs[4]  = '{1'b0,1'b1,5'd0,32'h12345678,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0, 1'b1,5'd0,1'b1,5'd0,
                     32'h0,32'h0,32'h0,32'h0,1'b0,4'd1};
        vecs[5]  = '{1'b0,1'b0,5'd0,32'h0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0, 1'b1,5'd0,1'b0,5'd3,
                     32'h0,32'h0,32'h0,32'h0,1'b0,4'd1};
        vecs[6]  = '{1'b0,1'b0,5'd0,32'h0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0, 1'b0,5'd3,1'b1,5'd3,
                     32'h0,32'hDEADBEEF,32'h0,32'h0,1'b0,4'd1};
        vecs[7]  = '{1'b0,1'b1,5'd3,32'h11111111,1'b1,32'hAAAA0000,32'h0000BBBB,1'b0,1'b0,1'b0,
                     1'b1,5'd3,1'b1,5'd4,
                     32'h11111111,32'h0,32'hAAAA0000,32'h0000BBBB,1'b0,4'd1};
        vecs[8]  = '{1'b0,1'b0,5'd0,32'h0,1'b0,32'h00001234,32'h00005678,1'b0,1'b0,1'b0,
                     1'b1,5'd3,1'b1,5'd3,
                     32'h11111111,32'h11111111,32'hAAAA0000,32'h0000BBBB,1'b0,4'd2};
        vecs[9]  = '{1'b0,1'b1,5'd31,32'hCAFEF00D,1'b0,32'h0,32'h0,1'b1,1'b1,1'b0,
                     1'b1,5'd3,1'b1,5'd31,
                     32'h11111111,32'hCAFEF00D,32'hAAAA0000,32'h0000BBBB,1'b1,4'd2};
        vecs[10] = '{1'b0,1'b0,5'd0,32'h0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0,
                     1'b1,5'd3,1'b1,5'd31,
                     32'h11111111,32'hCAFEF00D,32'hAAAA0000,32'h0000BBBB,1'b1,4'd3};
        vecs[11] = '{1'b0,1'b1,5'd4,32'h00000044,1'b1,32'h5,32'h6,1'b1,1'b1,1'b1,
                     1'b1,5'd4,1'b1,5'd31,
                     32'h44,32'hCAFEF00D,32'h5,32'h6,1'b0,4'd3};
        vecs[12] = '{1'b0,1'b0,5'd0,32'h0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0,
                     1'b1,5'd4,1'b1,5'd31,
                     32'h44,32'hCAFEF00D,32'h5,32'h6,1'b0,4'd4};
        vecs[13] = '{1'b0,1'b0,5'd0,32'h0,1'b0,32'h0,32'h0,1'b1,1'b1,1'b0,
                     1'b1,5'd4,1'b1,5'd31,
                     32'h44,32'hCAFEF00D,32'h5,32'h6,1'b1,4'd4};
        vecs[14] = '{1'b0,1'b0,5'd0,32'h0,1'b0,32'h0,32'h0,1'b1,1'b0,1'b0,
                     1'b1,5'd4,1'b1,5'd31,
                     32'h44,32'hCAFEF00D,32'h5,32'h6,1'b0,4'd4};
        vecs[15] = '{1'b0,1'b0,5'd0,32'h0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0,
                     1'b1,5'd4,1'b1,5'd31,
                     32'h44,32'hCAFEF00D,32'h5,32'h6,1'b0,4'd4};

        // First reset cycle: storage is undefined until the first edge, so no checks.
        drive(vecs[0]);

        for (int i = 0; i < 16; i++) begin
            run($sformatf("row%0d", i), vecs[i]);
        end

        // Counter wrap: 11 more writes take it from 4 to 15, then r7 wraps it to 0.
        v = vecs[15];
        v.re2   = 1'b0;
        v.e_rd2 = 32'h0;
        v.e_ll  = 1'b0;
        for (int i = 0; i < 11; i++) begin
            v.wreg  = 1'b1;
            v.wd    = 5'(i + 8);
            v.wdata = 32'(i + 32'h100);
            v.ra1   = 5'(i + 8);
            v.e_rd1 = 32'(i + 32'h100);
            v.e_cnt = CW'(i + 4);
            run($sformatf("fill%0d", i), v);
        end

        v.wd = 5'd7; v.wdata = 32'h77; v.ra1 = 5'd7; v.e_rd1 = 32'h77; v.e_cnt = 4'd15;
        run("wrap_write", v);

        v.wreg = 1'b0; v.e_cnt = 4'd0;
        run("wrap_after", v);

        // Reset mid-run with a pending write: the write is dropped and all state clears.
        v.rst = 1'b1; v.wreg = 1'b1; v.wd = 5'd7; v.wdata = 32'h99;
        v.e_rd1 = 32'h0; v.e_hi = 32'h0; v.e_lo = 32'h0; v.e_cnt = 4'd0;
        run("rst_mid", v);

        v.rst = 1'b0; v.wreg = 1'b0; v.wd = 5'd0; v.wdata = 32'h0;
        run("rst_after", v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
